// File: rtl/counter_pkg.sv
// Shared encodings for the mode counter: boundary modes and one-hot FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_STICKY = 2'b10
  } mode_t;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    CNTUP = 4'b0010,
    CNTDN = 4'b0100,
    FAULT = 4'b1000
  } state_t;

  // Mode 2'b11 behaves as STICKY, so only the upper mode bit selects sticky.
  function automatic logic is_sticky(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count datapath: applies one step of size s in the given
// direction and flags upper/lower boundary events. Holds count in sticky mode.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next,
  output logic             ovf_evt,
  output logic             unf_evt
);

  logic [WIDTH:0]   sum_ext;
  logic             above_limit;
  logic             step_zero;
  logic [WIDTH-1:0] s_lo;

  // sum_ext is exact at WIDTH+1 bits; the wrapped results are computed modulo
  // 2^WIDTH, which is exact because the true result always lies in 0..limit.
  assign sum_ext     = {1'b0, count} + s;
  assign above_limit = count > limit;
  assign step_zero   = (s == '0);
  assign s_lo        = s[WIDTH-1:0];

  // Select next value and classify the boundary event.
  always_comb begin
    next    = count;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!step_zero) begin
      if (above_limit) begin
        // Limit was lowered beneath the count: overflow in either direction.
        ovf_evt = 1'b1;
        if (!is_sticky(mode)) next = limit;
      end else if (up) begin
        if (sum_ext > {1'b0, limit}) begin
          ovf_evt = 1'b1;
          if (mode == MODE_WRAP)     next = count + s_lo - limit - WIDTH'(1);
          else if (mode == MODE_SAT) next = limit;
        end else begin
          next = count + s_lo;
        end
      end else begin
        if ({1'b0, count} < s) begin
          unf_evt = 1'b1;
          if (mode == MODE_WRAP)     next = count + limit + WIDTH'(1) - s_lo;
          else if (mode == MODE_SAT) next = '0;
        end else begin
          next = count - s_lo;
        end
      end
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with programmable inclusive limit, variable step, load and
// wrap/saturate/sticky-fault boundary handling.
//   state | meaning
//   IDLE  | no step this cycle (or just loaded / fault cleared); count held
//   CNTUP | last cycle stepped up
//   CNTDN | last cycle stepped down
//   FAULT | sticky boundary event seen; only clr_fault is honoured
module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  act,
  input  logic                  up_dwn_n,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      limit,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  clr_fault,
  output logic [WIDTH-1:0]      count,
  output logic                  ovflw,
  output logic                  unflw,
  output logic                  fault
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt, unf_nxt;

  logic [WIDTH:0]   lim1;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] step_val;
  logic             ovf_evt, unf_evt;

  // Effective step is clamped to limit+1 so one step never exceeds a full lap.
  assign lim1     = {1'b0, limit} + (WIDTH+1)'(1);
  assign step_ext = {{(WIDTH+1-STEP_WIDTH){1'b0}}, step};
  assign s        = (step_ext > lim1) ? lim1 : step_ext;

  counter_next #(.WIDTH(WIDTH)) u_next (
    .count   (count),
    .s       (s),
    .limit   (limit),
    .up      (up_dwn_n),
    .mode    (mode),
    .next    (step_val),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  // State, count and event pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      ovflw <= 1'b0;
      unflw <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      ovflw <= ovf_nxt;
      unflw <= unf_nxt;
    end
  end

  // Priority: fault handling, then load, then act.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (state == FAULT) begin
      if (clr_fault) begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    end else if (load) begin
      count_nxt = (load_val > limit) ? limit : load_val;
      state_nxt = IDLE;
    end else if (act) begin
      count_nxt = step_val;
      ovf_nxt   = ovf_evt;
      unf_nxt   = unf_evt;
      if (is_sticky(mode) && (ovf_evt || unf_evt)) state_nxt = FAULT;
      else if (up_dwn_n)                            state_nxt = CNTUP;
      else                                          state_nxt = CNTDN;
    end else begin
      state_nxt = IDLE;
    end
  end

  assign fault = (state == FAULT);

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter with WIDTH=8, STEP_WIDTH=4, limit=9.
module tb_mode_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       act;
  logic       up_dwn_n;
  logic [3:0] step;
  logic [7:0] limit;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic       clr_fault;
  logic [7:0] count;
  logic       ovflw, unflw, fault;

  int total = 0;
  int bad   = 0;

  mode_counter #(.WIDTH(8), .STEP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .act(act), .up_dwn_n(up_dwn_n), .step(step),
    .limit(limit), .mode(mode), .load(load), .load_val(load_val),
    .clr_fault(clr_fault), .count(count), .ovflw(ovflw), .unflw(unflw),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    act = 1'b0; load = 1'b0; clr_fault = 1'b0; step = 4'd0; up_dwn_n = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v; cyc(); load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; limit = 8'd9; mode = MODE_WRAP; load_val = 8'd0; idle_inputs();
    cyc(); cyc();
    total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({ovflw, unflw, fault} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {ovflw, unflw, fault}); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%b exp=%b", dut.state, IDLE); end
    rst = 1'b0; cyc();
  endtask

  task automatic test_wrap_up();
    mode = MODE_WRAP; do_load(8'd8);
    act = 1'b1; up_dwn_n = 1'b1; step = 4'd3; cyc(); act = 1'b0;
    total++; if (count !== 8'd1) begin bad++; $display("FAIL wrap_up_count got=%0d exp=1", count); end
    total++; if ({ovflw, unflw} !== 2'b10) begin bad++; $display("FAIL wrap_up_flags got=%b exp=10", {ovflw, unflw}); end
    total++; if (dut.state !== CNTUP) begin bad++; $display("FAIL wrap_up_state got=%b exp=%b", dut.state, CNTUP); end
    cyc();
    total++; if (ovflw !== 1'b0 || count !== 8'd1) begin bad++; $display("FAIL wrap_up_after got=%b/%0d exp=0/1", ovflw, count); end
  endtask

  task automatic test_wrap_down();
    mode = MODE_WRAP; do_load(8'd1);
    act = 1'b1; up_dwn_n = 1'b0; step = 4'd3; cyc(); act = 1'b0;
    total++; if (count !== 8'd8 || {ovflw, unflw} !== 2'b01) begin bad++; $display("FAIL wrap_down got=%0d/%b exp=8/01", count, {ovflw, unflw}); end
    total++; if (dut.state !== CNTDN) begin bad++; $display("FAIL wrap_down_state got=%b exp=%b", dut.state, CNTDN); end
  endtask

  task automatic test_sat_back_to_back();
    mode = MODE_SAT; do_load(8'd2);
    act = 1'b1; up_dwn_n = 1'b0; step = 4'd5;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++; if (count !== 8'd0 || unflw !== 1'b1 || ovflw !== 1'b0) begin bad++; $display("FAIL sat_down_%0d got=%0d/%b%b exp=0/01", i, count, ovflw, unflw); end
    end
    act = 1'b0; cyc();
    total++; if (unflw !== 1'b0) begin bad++; $display("FAIL sat_down_release got=%b exp=0", unflw); end
    do_load(8'd7);
    act = 1'b1; up_dwn_n = 1'b1; step = 4'd4; cyc(); act = 1'b0;
    total++; if (count !== 8'd9 || ovflw !== 1'b1) begin bad++; $display("FAIL sat_up got=%0d/%b exp=9/1", count, ovflw); end
  endtask

  task automatic test_sticky();
    mode = MODE_STICKY; do_load(8'd9);
    act = 1'b1; up_dwn_n = 1'b1; step = 4'd1; cyc(); act = 1'b0;
    total++; if (count !== 8'd9 || fault !== 1'b1) begin bad++; $display("FAIL sticky_event got=%0d/%b exp=9/1", count, fault); end
    load = 1'b1; load_val = 8'd3; act = 1'b1; up_dwn_n = 1'b0; cyc(); load = 1'b0; act = 1'b0;
    total++; if (count !== 8'd9 || fault !== 1'b1 || unflw !== 1'b0) begin bad++; $display("FAIL sticky_ignore got=%0d/%b/%b exp=9/1/0", count, fault, unflw); end
    clr_fault = 1'b1; cyc(); clr_fault = 1'b0;
    total++; if (count !== 8'd0 || fault !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL sticky_clear got=%0d/%b/%b exp=0/0/%b", count, fault, dut.state, IDLE); end
    mode = 2'b11; act = 1'b1; up_dwn_n = 1'b0; step = 4'd2; cyc(); act = 1'b0;
    total++; if (count !== 8'd0 || fault !== 1'b1 || unflw !== 1'b1) begin bad++; $display("FAIL mode3_sticky got=%0d/%b/%b exp=0/1/1", count, fault, unflw); end
    clr_fault = 1'b1; cyc(); clr_fault = 1'b0;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL mode3_clear got=%b exp=0", fault); end
  endtask

  task automatic test_load();
    mode = MODE_WRAP; do_load(8'd200);
    total++; if (count !== 8'd9) begin bad++; $display("FAIL load_clamp got=%0d exp=9", count); end
    load = 1'b1; load_val = 8'd4; act = 1'b1; up_dwn_n = 1'b1; step = 4'd1; cyc();
    load = 1'b0; act = 1'b0;
    total++; if (count !== 8'd4 || ovflw !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL load_over_act got=%0d/%b/%b exp=4/0/%b", count, ovflw, dut.state, IDLE); end
  endtask

  task automatic test_big_and_zero_step();
    mode = MODE_WRAP; do_load(8'd6);
    act = 1'b1; up_dwn_n = 1'b1; step = 4'd15; cyc();
    total++; if (count !== 8'd6 || ovflw !== 1'b1) begin bad++; $display("FAIL big_step got=%0d/%b exp=6/1", count, ovflw); end
    step = 4'd0; cyc(); act = 1'b0;
    total++; if (count !== 8'd6 || {ovflw, unflw} !== 2'b00) begin bad++; $display("FAIL zero_step got=%0d/%b exp=6/00", count, {ovflw, unflw}); end
  endtask

  task automatic test_limit_lowered();
    mode = MODE_WRAP; do_load(8'd8);
    limit = 8'd4; act = 1'b1; up_dwn_n = 1'b0; step = 4'd1; cyc(); act = 1'b0;
    total++; if (count !== 8'd4 || {ovflw, unflw} !== 2'b10) begin bad++; $display("FAIL limit_lowered got=%0d/%b exp=4/10", count, {ovflw, unflw}); end
    limit = 8'd9;
  endtask

  task automatic test_async_reset();
    mode = MODE_WRAP; do_load(8'd7);
    act = 1'b1; up_dwn_n = 1'b1; step = 4'd1;
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 8'd0 || {ovflw, unflw, fault} !== 3'b000) begin bad++; $display("FAIL async_reset got=%0d/%b exp=0/000", count, {ovflw, unflw, fault}); end
    cyc();
    rst = 1'b0;
    cyc();
    total++; if (count !== 8'd1) begin bad++; $display("FAIL resume_after_reset got=%0d exp=1", count); end
    act = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_sat_back_to_back();
    test_sticky();
    test_load();
    test_big_and_zero_step();
    test_limit_lowered();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
